// File: rtl/result_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// result_xfer_ctrl
//
// Sequencer that loads a DATA_W-bit ALU result into the byte-wide result
// register. An accepted start captures the operand, then the low byte
// (sl=1) and the high byte (sl=0) are presented with finala=0. finala stays
// low for SETTLE_CYC further cycles so the register's display and magnitude
// outputs settle. The register is then frozen with finala=1 and done pulses
// for one cycle.
//
// Ports
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   start        in   1        transfer request, honoured only in IDLE/HOLD
//   alu_result   in   DATA_W   operand, captured on an accepted start
//   clear        in   1        abort to IDLE; wins over start
//   result_data  out  BYTE_W   byte presented to the result register
//   sl           out  1        1 = low byte, 0 = high byte
//   finala       out  1        0 = register may update, 1 = frozen
//   busy         out  1        high while a transfer is in flight
//   done         out  1        one-cycle pulse on entering HOLD
//   neg          out  1        sign bit of the captured operand
// ---------------------------------------------------------------------------
module result_xfer_ctrl #(
  parameter int DATA_W     = 16,
  parameter int BYTE_W     = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              clear,
  output logic [BYTE_W-1:0] result_data,
  output logic              sl,
  output logic              finala,
  output logic              busy,
  output logic              done,
  output logic              neg
);

  if (DATA_W != 2 * BYTE_W || SETTLE_CYC < 2 || SETTLE_CYC > 15) begin : g_bad_param
    $error("result_xfer_ctrl: need DATA_W == 2*BYTE_W and SETTLE_CYC in 2..15");
  end

  // HOLD is split in two encodings so done can stay a pure state decode:
  // S_DONE is the first HOLD cycle, S_HOLD every later one.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_SETTLE,
    S_DONE,
    S_HOLD
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] op_q;
  logic [3:0]        cnt_q, cnt_d;
  logic              capture;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) op_q <= alu_result;
    end
  end

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_HOLD: begin
          if (start) begin
            capture = 1'b1;
            state_d = S_LO;
          end else if (state_q == S_DONE) begin
            state_d = S_HOLD;
          end
        end
        S_LO: state_d = S_HI;
        S_HI: begin
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          // Counter starts at SETTLE_CYC-1, so SETTLE lasts SETTLE_CYC cycles.
          if (cnt_q == 4'd0) state_d = S_DONE;
          else               cnt_d   = cnt_q - 4'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore output decode. The idle/hold defaults (finala=1, sl=1) keep the
  // result register frozen, which matters in reset: finala=0 with sl=0 would
  // overwrite its high byte.
  always_comb begin
    result_data = '0;
    sl          = 1'b1;
    finala      = 1'b1;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      S_LO: begin
        finala      = 1'b0;
        busy        = 1'b1;
        result_data = op_q[BYTE_W-1:0];
      end
      S_HI, S_SETTLE: begin
        finala      = 1'b0;
        sl          = 1'b0;
        busy        = 1'b1;
        result_data = op_q[DATA_W-1:BYTE_W];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Only a capture changes op_q, so neg holds through IDLE/HOLD and clear.
  assign neg = op_q[DATA_W-1];

endmodule

// File: tb/tb_result_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_result_xfer_ctrl
//
// Directed bench for result_xfer_ctrl. A small behavioural model of the
// downstream result register (byte latches, display word, magnitude) sits on
// the DUT outputs so transfers can be judged by what the register would show.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_result_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] alu_result;
  logic        clear;
  logic [7:0]  result_data;
  logic        sl, finala, busy, done, neg;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  result_xfer_ctrl #(.DATA_W(16), .BYTE_W(8), .SETTLE_CYC(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu_result  (alu_result),
    .clear       (clear),
    .result_data (result_data),
    .sl          (sl),
    .finala      (finala),
    .busy        (busy),
    .done        (done),
    .neg         (neg)
  );

  always #5 clk = ~clk;

  // Result register model: byte writes when finala=0, display word one edge
  // later, magnitude (two's-complement absolute value) one edge after that.
  logic [7:0]  st_lo = 8'h00;
  logic [7:0]  st_hi = 8'h00;
  logic [15:0] disp  = 16'h0000;
  logic [15:0] mag   = 16'h0000;

  always @(posedge clk) begin
    if (!finala) begin
      if (sl) st_lo <= result_data;
      else    st_hi <= result_data;
    end
    disp <= {st_hi, st_lo};
    mag  <= disp[15] ? 16'(-disp) : disp;
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Starts a transfer at the current falling edge and follows it to done.
  task automatic xfer_now(input logic [15:0] val, input logic [15:0] exp_mag,
                          input string tag);
    int lat;
    start      = 1'b1;
    alu_result = val;
    @(negedge clk);                       // LO
    start      = 1'b0;
    alu_result = 16'hDEAD;
    check({tag, "_lo_byte"}, 32'(result_data), 32'(val[7:0]));
    check({tag, "_lo_sl"}, 32'(sl), 32'd1);
    check({tag, "_lo_finala"}, 32'(finala), 32'd0);
    check({tag, "_lo_busy"}, 32'(busy), 32'd1);
    @(negedge clk);                       // HI
    check({tag, "_hi_byte"}, 32'(result_data), 32'(val[15:8]));
    check({tag, "_hi_sl"}, 32'(sl), 32'd0);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_display"}, 32'(disp), 32'(val));
    check({tag, "_magnitude"}, 32'(mag), 32'(exp_mag));
    check({tag, "_neg"}, 32'(neg), 32'(val[15]));
    check({tag, "_done_finala"}, 32'(finala), 32'd1);
  endtask

  task automatic xfer(input logic [15:0] val, input logic [15:0] exp_mag,
                      input string tag);
    @(negedge clk);
    xfer_now(val, exp_mag, tag);
  endtask

  initial begin
    int c0;
    rst_n      = 1'b0;
    start      = 1'b0;
    clear      = 1'b0;
    alu_result = 16'h0000;

    // Reset values, then 20 idle cycles with the register left alone.
    repeat (2) @(negedge clk);
    check("rst_data", 32'(result_data), 32'h0);
    check("rst_sl", 32'(sl), 32'd1);
    check("rst_finala", 32'(finala), 32'd1);
    check("rst_busy_done_neg", {29'd0, busy, done, neg}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ctrl", {28'd0, finala, sl, busy, done}, 32'b1100);
    end
    check("idle_display", 32'(disp), 32'h0);

    // Plain transfers, including sign and most-negative boundaries.
    xfer(16'h1234, 16'h1234, "x1234");
    @(negedge clk);
    check("x1234_done_one_cycle", 32'(done), 32'd0);
    xfer(16'hFFFE, 16'h0002, "xFFFE");
    xfer(16'h8000, 16'h8000, "x8000");

    // start while busy is ignored; only one done, operand unchanged.
    @(negedge clk);
    c0 = done_cnt;
    start = 1'b1; alu_result = 16'h00FF;
    @(negedge clk);                       // LO
    alu_result = 16'hAAAA;
    check("busy_ign_lo", 32'(result_data), 32'hFF);
    @(negedge clk);                       // HI
    check("busy_ign_hi", 32'(result_data), 32'h00);
    @(negedge clk);                       // SETTLE 1
    @(negedge clk);                       // SETTLE 2
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_ign_done_cnt", 32'(done_cnt - c0), 32'd1);
    check("busy_ign_display", 32'(disp), 32'h00FF);
    check("busy_ign_neg", 32'(neg), 32'd0);

    // Back-to-back: start in the done cycle goes straight to LO.
    xfer(16'h1234, 16'h1234, "b2b_first");
    xfer_now(16'h0102, 16'h0102, "b2b_second");

    // Asynchronous reset during HI.
    @(negedge clk);
    start = 1'b1; alu_result = 16'h9678;
    @(negedge clk);                       // LO
    start = 1'b0;
    @(negedge clk);                       // HI
    check("arst_pre_sl", 32'(sl), 32'd0);
    check("arst_pre_neg", 32'(neg), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_data", 32'(result_data), 32'h0);
    check("arst_ctrl", {27'd0, sl, finala, busy, done, neg}, 32'b11000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle_busy", 32'(busy), 32'd0);

    // clear during SETTLE aborts with no done; neg is kept.
    @(negedge clk);
    start = 1'b1; alu_result = 16'hC321;
    @(negedge clk);                       // LO
    start = 1'b0;
    @(negedge clk);                       // HI
    @(negedge clk);                       // SETTLE
    check("clr_in_settle", {30'd0, finala, busy}, 32'b01);
    c0 = done_cnt;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_ctrl", {28'd0, finala, sl, busy, done}, 32'b1100);
    check("clr_neg_kept", 32'(neg), 32'd1);
    repeat (6) @(negedge clk);
    check("clr_no_done", 32'(done_cnt - c0), 32'd0);

    // clear together with start stays in IDLE.
    clear = 1'b1; start = 1'b1; alu_result = 16'h0011;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    check("clr_start_busy", 32'(busy), 32'd0);
    check("clr_start_neg", 32'(neg), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
